// File: rtl/control_unit.sv
// Decode/sequencing FSM for SPARC-V8 format-3 ALU instructions: DECODE -> EXEC -> WB.
// Optional macro CU_CC_UPDATE_EN enables PSR_Enable for the cc-setting op3 variants.
module control_unit (
  input  logic       Clk,
  input  logic       RESET,
  input  logic [31:0] IR_Out,
  input  logic       MFC,
  output logic       NPC_enable,
  output logic       PC_enable,
  output logic       MDR_Enable,
  output logic       MAR_Enable,
  output logic       RAM_enable,
  output logic       register_file_enable,
  output logic       PSR_Enable,
  output logic [2:0] extender_select,
  output logic [1:0] PC_In_Mux_select,
  output logic [1:0] ALUA_Mux_select,
  output logic [2:0] ALUB_Mux_select,
  output logic       MDR_Mux_select,
  output logic [4:0] in_PA,
  output logic [4:0] in_PB,
  output logic [4:0] in_PC,
  output logic [5:0] ALU_op,
  output logic [5:0] RAM_OpCode
);

  typedef enum logic [1:0] {ST_RST, ST_DECODE, ST_EXEC, ST_WB} state_t;

  state_t     state, state_next;
  logic [4:0] rd_q, rs1_q, rs2_q;
  logic [5:0] op3_q;
  logic       i_q;
  logic       legal;

  // Memory path and immediate bits are not used by the ALU-only sequence.
  logic unused_inputs;
  assign unused_inputs = ^{MFC, IR_Out[12:5]};

  always_comb begin
    legal = 1'b0;
    if (IR_Out[31:30] == 2'b10) begin
      unique case (IR_Out[24:19])
        6'b000000, 6'b000001, 6'b000010, 6'b000011,
        6'b000100, 6'b000101, 6'b000110, 6'b000111,
        6'b010000, 6'b010001, 6'b010010, 6'b010011,
        6'b010100, 6'b010101, 6'b010110, 6'b010111,
        6'b100101, 6'b100110, 6'b100111: legal = 1'b1;
        default:                         legal = 1'b0;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!RESET) state <= ST_RST;
    else        state <= state_next;
  end

  // NOTE: decode fields have no reset; they only reach the outputs in EXEC/WB,
  // which can only be entered through a DECODE edge that loads them.
  always_ff @(posedge Clk) begin
    if (state == ST_DECODE && legal) begin
      rd_q  <= IR_Out[29:25];
      op3_q <= IR_Out[24:19];
      rs1_q <= IR_Out[18:14];
      i_q   <= IR_Out[13];
      rs2_q <= IR_Out[4:0];
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_RST:    state_next = ST_DECODE;
      ST_DECODE: state_next = legal ? ST_EXEC : ST_DECODE;
      ST_EXEC:   state_next = ST_WB;
      ST_WB:     state_next = ST_DECODE;
      default:   state_next = ST_RST;
    endcase
  end

  // Moore outputs: decoded only from the state register and latched fields.
  always_comb begin
    register_file_enable = 1'b0;
    PSR_Enable           = 1'b0;
    ALUB_Mux_select      = 3'd0;
    in_PA                = 5'd0;
    in_PB                = 5'd0;
    in_PC                = 5'd0;
    ALU_op               = 6'd0;
    if (state == ST_EXEC || state == ST_WB) begin
      in_PA           = rs1_q;
      in_PB           = rs2_q;
      in_PC           = rd_q;
      ALU_op          = op3_q;
      ALUB_Mux_select = i_q ? 3'd1 : 3'd0;
    end
    if (state == ST_WB) register_file_enable = 1'b1;
`ifdef CU_CC_UPDATE_EN
    if (state == ST_EXEC) PSR_Enable = op3_q[4];
`else
    PSR_Enable = 1'b0;
`endif
  end

  assign NPC_enable       = 1'b0;
  assign PC_enable        = 1'b0;
  assign MDR_Enable       = 1'b0;
  assign MAR_Enable       = 1'b0;
  assign RAM_enable       = 1'b0;
  assign extender_select  = 3'd0;
  assign PC_In_Mux_select = 2'd0;
  assign ALUA_Mux_select  = 2'd0;
  assign MDR_Mux_select   = 1'b0;
  assign RAM_OpCode       = 6'd0;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: vector table plus hand sequences, outputs
// checked each cycle against a scoreboard queue. Honours CU_CC_UPDATE_EN if defined.
module tb_control_unit;

  logic        Clk = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] IR_Out = '0;
  logic        MFC = 1'b0;
  logic        NPC_enable, PC_enable, MDR_Enable, MAR_Enable, RAM_enable;
  logic        register_file_enable, PSR_Enable, MDR_Mux_select;
  logic [2:0]  extender_select, ALUB_Mux_select;
  logic [1:0]  PC_In_Mux_select, ALUA_Mux_select;
  logic [4:0]  in_PA, in_PB, in_PC;
  logic [5:0]  ALU_op, RAM_OpCode;

  control_unit dut (
    .Clk(Clk), .RESET(RESET), .IR_Out(IR_Out), .MFC(MFC),
    .NPC_enable(NPC_enable), .PC_enable(PC_enable), .MDR_Enable(MDR_Enable),
    .MAR_Enable(MAR_Enable), .RAM_enable(RAM_enable),
    .register_file_enable(register_file_enable), .PSR_Enable(PSR_Enable),
    .extender_select(extender_select), .PC_In_Mux_select(PC_In_Mux_select),
    .ALUA_Mux_select(ALUA_Mux_select), .ALUB_Mux_select(ALUB_Mux_select),
    .MDR_Mux_select(MDR_Mux_select), .in_PA(in_PA), .in_PB(in_PB), .in_PC(in_PC),
    .ALU_op(ALU_op), .RAM_OpCode(RAM_OpCode)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [18:0] zeros;
    logic        rf_en;
    logic        psr_en;
    logic [2:0]  alub;
    logic [4:0]  pa, pb, pc;
    logic [5:0]  alu_op;
  } out_t;

  typedef struct {
    string name;
    out_t  exp;
  } sb_t;

  typedef struct {
    string       name;
    logic [31:0] ir;
    bit          legal;
    bit          i;
    logic [4:0]  rs1, rs2, rd;
    logic [5:0]  op3;
  } vec_t;

  sb_t  sb[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  `ifdef CU_CC_UPDATE_EN
  localparam bit CC_EN = 1'b1;
  `else
  localparam bit CC_EN = 1'b0;
  `endif

  function automatic out_t actual();
    out_t a;
    a.zeros  = {NPC_enable, PC_enable, MDR_Enable, MAR_Enable, RAM_enable,
                extender_select, PC_In_Mux_select, ALUA_Mux_select,
                MDR_Mux_select, RAM_OpCode};
    a.rf_en  = register_file_enable;
    a.psr_en = PSR_Enable;
    a.alub   = ALUB_Mux_select;
    a.pa     = in_PA;
    a.pb     = in_PB;
    a.pc     = in_PC;
    a.alu_op = ALU_op;
    return a;
  endfunction

  function automatic out_t exp_active(input vec_t v, input bit wb);
    out_t e = '0;
    e.pa     = v.rs1;
    e.pb     = v.rs2;
    e.pc     = v.rd;
    e.alu_op = v.op3;
    e.alub   = v.i ? 3'd1 : 3'd0;
    e.rf_en  = wb;
    e.psr_en = CC_EN && !wb && v.op3[4];
    return e;
  endfunction

  function automatic vec_t hx(input string name, input logic [31:0] ir, input bit legal,
                              input bit i, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [5:0] op3);
    vec_t v;
    v.name = name; v.ir = ir; v.legal = legal; v.i = i;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.op3 = op3;
    return v;
  endfunction

  function automatic vec_t mk(input string name, input logic [1:0] op, input logic [4:0] rd,
                              input logic [5:0] op3, input logic [4:0] rs1, input bit i,
                              input logic [4:0] rs2, input bit legal);
    return hx(name, {op, rd, op3, rs1, i, 8'hA5, rs2}, legal, i, rs1, rs2, rd, op3);
  endfunction

  // Inputs are applied across the next rising edge; exp is what the outputs
  // must show for the cycle that edge starts.
  task automatic drive(input logic [31:0] ir, input logic rst, input out_t exp,
                       input string name);
    IR_Out = ir;
    RESET  = rst;
    MFC    = 1'($urandom_range(0, 1));
    @(posedge Clk);
    #1;
    sb.push_back('{name, exp});
  endtask

  always @(negedge Clk) begin
    if (sb.size() > 0) begin
      sb_t  s;
      out_t a;
      s = sb.pop_front();
      a = actual();
      n_checks++;
      if (a !== s.exp) begin
        n_fail++;
        $display("FAIL %s: got %h (rf=%b psr=%b alub=%0d pa=%0d pb=%0d pc=%0d op=%h) want %h (rf=%b psr=%b alub=%0d pa=%0d pb=%0d pc=%0d op=%h)",
                 s.name, a, a.rf_en, a.psr_en, a.alub, a.pa, a.pb, a.pc, a.alu_op,
                 s.exp, s.exp.rf_en, s.exp.psr_en, s.exp.alub, s.exp.pa, s.exp.pb,
                 s.exp.pc, s.exp.alu_op);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vecs.push_back(hx("add_r1_imm3",  32'h82002003, 1, 1, 5'd0, 5'd3, 5'd1, 6'h00));
    vecs.push_back(hx("add_r2_imm6",  32'h84002006, 1, 1, 5'd0, 5'd6, 5'd2, 6'h00));
    vecs.push_back(hx("add_r2_r1_r2", 32'h84004002, 1, 0, 5'd1, 5'd2, 5'd2, 6'h00));
    vecs.push_back(hx("addcc_imm1",   32'h84802001, 1, 1, 5'd0, 5'd1, 5'd2, 6'h10));
    vecs.push_back(hx("op11_illegal", 32'hC2002000, 0, 0, 5'd0, 5'd0, 5'd0, 6'h00));
    vecs.push_back(mk("xnor",          2'b10, 5'd31, 6'b000111, 5'd17, 0, 5'd9,  1));
    vecs.push_back(mk("op3_08_illegal",2'b10, 5'd4,  6'b001000, 5'd1,  0, 5'd2,  0));
    vecs.push_back(mk("xnorcc",        2'b10, 5'd5,  6'b010111, 5'd30, 1, 5'd21, 1));
    vecs.push_back(mk("op3_18_illegal",2'b10, 5'd6,  6'b011000, 5'd2,  1, 5'd3,  0));
    vecs.push_back(mk("sll",           2'b10, 5'd3,  6'b100101, 5'd4,  0, 5'd7,  1));
    vecs.push_back(mk("op3_24_illegal",2'b10, 5'd7,  6'b100100, 5'd5,  0, 5'd8,  0));
    vecs.push_back(mk("sra",           2'b10, 5'd0,  6'b100111, 5'd12, 1, 5'd31, 1));
    vecs.push_back(mk("op3_28_illegal",2'b10, 5'd8,  6'b101000, 5'd6,  0, 5'd9,  0));
    vecs.push_back(mk("op00_illegal",  2'b00, 5'd9,  6'b000000, 5'd7,  0, 5'd10, 0));

    // Reset held two cycles, then released into DECODE.
    drive(32'h82002003, 1'b0, '0, "reset_1");
    drive(32'h82002003, 1'b0, '0, "reset_2");
    drive(32'h82002003, 1'b1, '0, "rst_to_decode");

    foreach (vecs[k]) begin
      v = vecs[k];
      if (v.legal) begin
        drive(v.ir, 1'b1, exp_active(v, 1'b0), {v.name, "_exec"});
        drive($urandom, 1'b1, exp_active(v, 1'b1), {v.name, "_wb"});
        drive($urandom, 1'b1, '0, {v.name, "_decode"});
      end else begin
        drive(v.ir, 1'b1, '0, {v.name, "_hold1"});
        drive(v.ir, 1'b1, '0, {v.name, "_hold2"});
      end
    end

    // Reset during EXEC: no WB follows, outputs drop to 0.
    v = vecs[0];
    drive(v.ir, 1'b1, exp_active(v, 1'b0), "rst_exec_exec");
    drive(v.ir, 1'b0, '0, "rst_exec_abort");
    drive(v.ir, 1'b1, '0, "rst_exec_decode");

    // Reset during WB, then a fresh instruction runs normally.
    v = vecs[2];
    drive(v.ir, 1'b1, exp_active(v, 1'b0), "rst_wb_exec");
    drive(v.ir, 1'b1, exp_active(v, 1'b1), "rst_wb_wb");
    drive(v.ir, 1'b0, '0, "rst_wb_abort");
    drive(v.ir, 1'b1, '0, "rst_wb_decode");
    v = vecs[3];
    drive(v.ir, 1'b1, exp_active(v, 1'b0), "post_rst_exec");
    drive(v.ir, 1'b1, exp_active(v, 1'b1), "post_rst_wb");
    drive(v.ir, 1'b1, '0, "post_rst_decode");

    for (int k = 0; k < 4 && sb.size() != 0; k++) @(negedge Clk);
    #1;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
